pps_timebase: RTL and testbench
===============================

# pps_timebase

Parametrised one-second timebase that generates a 1 µs tick, a microsecond-of-second count, a running seconds count and a PPS pulse of programmable width, all from a single fabric clock (typically the PLL output). It replaces hand-tuned cascaded decade counters with a generic prescaler and second counter. With the sync option compiled in, it phase-aligns to an external PPS reference. It sits next to the PLL and feeds timestamping and LED/debug logic.

## Interface
- `CLK_HZ`, default 100_000_000, input clock frequency. `CLK_HZ/1_000_000` must be an integer ≥ 2; call it DIV.
- `SEC_US`, default 1_000_000, microseconds per "second". Reduced only for simulation; must be ≥ 4.
- `PULSE_US`, default 1000, PPS high time in µs; legal range 1..SEC_US-1.
- `SEC_W`, default 32, width of the seconds counter.
- Derived: USEC_W = $clog2(SEC_US).
- `clk`  in  1  sole clock; all logic rises on posedge clk.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; low freezes the timebase.
- `sync_in`  in  1  external PPS, asynchronous to clk; used only with `PPS_SYNC_EN`.
- `us_tick`  out  1  one-cycle strobe at each microsecond boundary.
- `usec`  out  USEC_W  microsecond within the current second, 0..SEC_US-1.
- `seconds`  out  SEC_W  completed seconds since reset; wraps modulo 2^SEC_W.
- `pps`  out  1  PPS pulse, registered.

## Operation
- **Reset** (rst_n low, async): prescaler=0, `usec`=0, `seconds`=0, `pps`=0, `us_tick`=0, sync pipeline cleared. No pulse is emitted at reset.
- **Prescaler:** counts 0..DIV-1 while `en`=1. The "wrap cycle" is the cycle with prescaler==DIV-1 and `en`=1.
- **us_tick:** registered. High for exactly the one cycle following each wrap cycle.
- **Microsecond counter:** `usec` increments on each wrap cycle.
- **Rollover:** a wrap cycle with `usec`==SEC_US-1 is a rollover. At the next edge: `usec`<=0, `seconds`<=seconds+1, `pps`<=1.
- **PPS deassert:** `pps`<=0 on the edge where `usec` becomes PULSE_US. The pulse therefore lasts exactly PULSE_US×DIV clk cycles.
- **en low:** prescaler, `usec`, `seconds` and `pps` hold their values, and `us_tick`=0. If `pps` was high, it stays high, and its remaining width resumes when `en` returns high. Counting resumes from the held prescaler value with no lost or extra cycles.
- **Arithmetic:** all counters wrap silently. `seconds` wraps 2^SEC_W-1 → 0 with no flag.

## Timing
- From rst_n release with `en`=1:
  - first `us_tick` in cycle DIV (cycles numbered from 1 after release);
  - first `pps` rise DIV×SEC_US cycles after release;
  - `seconds` becomes 1 on the same edge as that `pps` rise.
- `usec`, `seconds`, `pps` and `us_tick` are all registered outputs with no combinational paths from inputs.
- **sync_in latency (PPS_SYNC_EN):** 2-flop synchronizer, then a registered rising-edge detect. Realignment takes effect 3 clk edges after the `sync_in` rise is sampled.

## Configuration
- **`PPS_SYNC_EN` defined:** on a detected `sync_in` rising edge (sync event), regardless of `en`:
  - prescaler<=0, `usec`<=0, `pps`<=1.
  - `seconds` increments only if `usec` ≥ SEC_US/2 at the event (reference slightly early). Otherwise it is held (internal rollover already counted this second).
  - A sync event coincident with an internal rollover produces a single increment.
  - `us_tick`=0 on the event cycle.
  - A sync event while `pps` is high restarts the PULSE_US width.
- **`PPS_SYNC_EN` undefined:** `sync_in` is unused (port kept, no logic), and the timebase is free-running.

## Test plan
Benches use CLK_HZ=4_000_000 (DIV=4), SEC_US=10, PULSE_US=3, SEC_W=4 unless stated.

- **Reset/first pulse:** release rst_n with `en`=1.
  - `us_tick` at cycle 4, then every 4 cycles.
  - `pps` rises at cycle 40, high for 12 cycles.
  - `seconds`=1 at the rise; `usec` sequence 0..9,0.
- **Wrap:** run 16 s. `seconds` goes 15 → 0, and the `pps` period stays exactly 40 cycles throughout.
- **Enable gating:** drop `en` for 7 cycles mid-pulse (`usec`=1).
  - Outputs hold and `us_tick` stays 0.
  - Total `pps` high time is still 12 enabled cycles; the next rise is delayed by exactly 7 cycles.
- **Async reset mid-pulse:** assert rst_n low while `pps`=1 and `seconds`=5. All outputs go 0 immediately (before the next edge), and the restart matches the reset scenario.
- **Sync late/early (PPS_SYNC_EN):**
  - Pulse `sync_in` when `usec`=7: 3 edges later `usec`=0, `pps`=1, `seconds`+1.
  - Pulse `sync_in` when `usec`=2 after a rollover: realigns, `seconds` unchanged.
- **Sync coincident/undefined:**
  - Sync event timed on the rollover edge yields a single `seconds` increment.
  - With `PPS_SYNC_EN` undefined, `sync_in` toggling has no effect on any output.

Source files
------------

// File: rtl/pps_timebase.sv
// One-second timebase: 1 us tick, microsecond-of-second, seconds count and programmable-width PPS.
// Define PPS_SYNC_EN to phase-align the timebase to an external PPS reference on sync_in.
module pps_timebase #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SEC_US   = 1_000_000,
  parameter int unsigned PULSE_US = 1000,
  parameter int unsigned SEC_W    = 32,
  localparam int unsigned USEC_W  = $clog2(SEC_US)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_in,
  output logic              us_tick,
  output logic [USEC_W-1:0] usec,
  output logic [SEC_W-1:0]  seconds,
  output logic              pps
);

  localparam int unsigned DIV   = CLK_HZ / 1_000_000;
  localparam int unsigned PRE_W = $clog2(DIV);

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [USEC_W-1:0] USEC_LAST  = USEC_W'(SEC_US - 1);
  localparam logic [USEC_W-1:0] PULSE_LAST = USEC_W'(PULSE_US - 1);

  logic [PRE_W-1:0] pre;
  logic             wrap;
  logic             rollover;
  logic             pulse_end;
  logic             sync_evt;

  assign wrap      = en && (pre == PRE_LAST);
  assign rollover  = wrap && (usec == USEC_LAST);
  // Deassert on the edge where usec becomes PULSE_US.
  assign pulse_end = wrap && (usec == PULSE_LAST);

`ifdef PPS_SYNC_EN
  localparam logic [USEC_W-1:0] USEC_HALF = USEC_W'(SEC_US / 2);

  logic sync_meta;
  logic sync_q;
  logic sync_q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_q_d  <= 1'b0;
      sync_evt  <= 1'b0;
    end else begin
      sync_meta <= sync_in;
      sync_q    <= sync_meta;
      sync_q_d  <= sync_q;
      sync_evt  <= sync_q & ~sync_q_d;
    end
  end
`else
  logic unused_sync;
  assign unused_sync = sync_in;
  assign sync_evt    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      usec    <= '0;
      seconds <= '0;
      pps     <= 1'b0;
      us_tick <= 1'b0;
    end else if (sync_evt) begin
`ifdef PPS_SYNC_EN
      // A reference arriving in the second half of our second means we have not yet counted it.
      if (usec >= USEC_HALF) seconds <= seconds + SEC_W'(1);
`endif
      pre     <= '0;
      usec    <= '0;
      pps     <= 1'b1;
      us_tick <= 1'b0;
    end else begin
      us_tick <= wrap;
      if (en) pre <= wrap ? '0 : pre + PRE_W'(1);
      if (wrap) usec <= rollover ? '0 : usec + USEC_W'(1);
      if (rollover) begin
        seconds <= seconds + SEC_W'(1);
        pps     <= 1'b1;
      end else if (pulse_end) begin
        pps <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pps_timebase.sv
// Scoreboard bench for pps_timebase (DIV=4, SEC_US=10, PULSE_US=3, SEC_W=4); the model derives
// expected outputs from a count of enabled cycles since the last alignment point.
module tb_pps_timebase;

  localparam int DIV       = 4;
  localparam int SEC_US    = 10;
  localparam int PERIOD    = DIV * SEC_US;
  localparam int PULSE_CYC = 3 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync_in = 1'b0;
  logic       us_tick;
  logic       pps;
  logic [3:0] usec;
  logic [3:0] seconds;
  logic [9:0] obs;
  logic [9:0] exp_v;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] sb[$];

  pps_timebase #(
    .CLK_HZ(4_000_000),
    .SEC_US(10),
    .PULSE_US(3),
    .SEC_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .sync_in(sync_in),
    .us_tick(us_tick),
    .usec(usec),
    .seconds(seconds),
    .pps(pps)
  );

  assign obs = {us_tick, usec, seconds, pps};

  always #5 clk = ~clk;

  // Reference model: pushes the expected post-edge outputs at every rising edge.
  int unsigned m_ecnt;
  int unsigned m_sec;
  bit          m_fired;
  bit          m_tick;
  logic [4:0]  m_hist;

  always @(posedge clk) begin
    bit evt;
    if (!rst_n) begin
      m_ecnt  = 0;
      m_sec   = 0;
      m_fired = 0;
      m_tick  = 0;
      m_hist  = '0;
    end else begin
      m_hist = {m_hist[3:0], sync_in};
`ifdef PPS_SYNC_EN
      evt = m_hist[3] & ~m_hist[4];
`else
      evt = 1'b0;
`endif
      if (evt) begin
        if (((m_ecnt % PERIOD) / DIV) >= SEC_US / 2) m_sec = m_sec + 1;
        m_ecnt  = 0;
        m_fired = 1;
        m_tick  = 0;
      end else if (en) begin
        m_ecnt = m_ecnt + 1;
        m_tick = (m_ecnt % DIV) == 0;
        if ((m_ecnt % PERIOD) == 0) begin
          m_sec   = m_sec + 1;
          m_fired = 1;
        end
      end else begin
        m_tick = 0;
      end
    end
    sb.push_back({m_tick, 4'((m_ecnt / DIV) % SEC_US), 4'(m_sec),
                  m_fired && ((m_ecnt % PERIOD) < PULSE_CYC)});
  end

  task automatic test_reset();
    int first_tick = -1, rise = -1, fall = -1;
    logic [3:0] sec_at_rise = '1;
    bit prev_pps = 0;
    rst_n = 1'b0; en = 1'b0; sync_in = 1'b0;
    for (int c = -2; c <= 60; c++) begin
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL reset_sb_empty c=%0d", c);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL reset c=%0d got=%b exp=%b", c, obs, exp_v);
        end
      end
      if (c <= 0) begin
        vectors++;
        if (obs !== 10'b0) begin
          miscompares++; $display("FAIL reset_state c=%0d got=%b exp=%b", c, obs, 10'b0);
        end
      end
      if (c == 0) begin rst_n = 1'b1; en = 1'b1; end
      if (c > 0) begin
        if (us_tick && first_tick < 0) first_tick = c;
        if (pps && !prev_pps) begin rise = c; sec_at_rise = seconds; end
        if (!pps && prev_pps) fall = c;
        prev_pps = pps;
      end
    end
    vectors += 4;
    if (first_tick !== 4) begin miscompares++; $display("FAIL first_tick got=%0d exp=4", first_tick); end
    if (rise !== 40) begin miscompares++; $display("FAIL first_rise got=%0d exp=40", rise); end
    if (fall - rise !== 12) begin miscompares++; $display("FAIL pulse_width got=%0d exp=12", fall - rise); end
    if (sec_at_rise !== 4'd1) begin miscompares++; $display("FAIL sec_at_rise got=%0d exp=1", sec_at_rise); end
  endtask

  task automatic test_wrap();
    int last_rise = -1;
    bit wrapped = 0;
    bit prev_pps = pps;
    logic [3:0] prev_rs = seconds;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL wrap_sb_empty c=%0d", c);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL wrap c=%0d got=%b exp=%b", c, obs, exp_v);
        end
      end
      if (pps && !prev_pps) begin
        if (last_rise >= 0) begin
          vectors++;
          if (c - last_rise !== PERIOD) begin
            miscompares++; $display("FAIL wrap_period got=%0d exp=%0d", c - last_rise, PERIOD);
          end
          if (prev_rs == 4'd15 && seconds == 4'd0) wrapped = 1;
        end
        last_rise = c;
        prev_rs   = seconds;
      end
      prev_pps = pps;
    end
    vectors++;
    if (!wrapped) begin miscompares++; $display("FAIL seconds_wrap got=0 exp=1"); end
  endtask

  task automatic test_en_gating();
    int st = 0, r0 = 0, fall = 0, r1 = 0, gate = 0;
    bit prev_pps = pps;
    logic [9:0] snap = '0;
    for (int c = 0; c < 160 && st != 5; c++) begin
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL gate_sb_empty c=%0d", c);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL gate c=%0d got=%b exp=%b", c, obs, exp_v);
        end
      end
      case (st)
        0: if (pps && !prev_pps) begin r0 = c; st = 1; end
        1: if (pps && usec == 4'd1) begin en = 1'b0; snap = obs; st = 2; end
        2: begin
          gate++;
          vectors++;
          if (obs !== {1'b0, snap[8:0]}) begin
            miscompares++; $display("FAIL gate_hold c=%0d got=%b exp=%b", c, obs, {1'b0, snap[8:0]});
          end
          if (gate == 7) begin en = 1'b1; st = 3; end
        end
        3: if (!pps && prev_pps) begin fall = c; st = 4; end
        4: if (pps && !prev_pps) begin r1 = c; st = 5; end
        default: ;
      endcase
      prev_pps = pps;
    end
    en = 1'b1;
    vectors += 2;
    if (st !== 5) begin
      miscompares++; $display("FAIL gate_timeout got=%0d exp=5", st);
    end
    if (fall - r0 !== PULSE_CYC + 7 || r1 - r0 !== PERIOD + 7) begin
      miscompares++;
      $display("FAIL gate_timing got=%0d/%0d exp=%0d/%0d", fall - r0, r1 - r0, PULSE_CYC + 7, PERIOD + 7);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL arst_sb_empty c=%0d", c);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL arst c=%0d got=%b exp=%b", c, obs, exp_v);
        end
      end
      if (pps && seconds == 4'd5) begin
        found = 1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 10'b0) begin
          miscompares++; $display("FAIL arst_immediate got=%b exp=%b", obs, 10'b0);
        end
      end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL arst_timeout got=0 exp=1"); end
    test_reset();
  endtask

`ifdef PPS_SYNC_EN
  // mode 0: late (usec=7), 1: early after a rollover (usec=2), 2: coincident with rollover.
  task automatic test_sync(input int mode);
    int k = -1;
    bit seen9 = 0, done = 0;
    logic [3:0] s0 = '0;
    logic [3:0] s_exp;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL sync%0d_sb_empty c=%0d", mode, c);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL sync%0d c=%0d got=%b exp=%b", mode, c, obs, exp_v);
        end
      end
      if (k >= 0) k++;
      if (k == 1) sync_in = 1'b0;
      s_exp = (mode == 1) ? s0 : 4'(s0 + 1);
      if (k == 4 || (mode == 2 && k == 5)) begin
        vectors++;
        if ({usec == 4'd0 || k == 5, pps, seconds} !== {2'b11, s_exp}) begin
          miscompares++;
          $display("FAIL sync%0d_align k=%0d got=usec%0d/pps%b/sec%0d exp=usec0/pps1/sec%0d",
                   mode, k, usec, pps, seconds, s_exp);
        end
        if (mode != 2 || k == 5) done = 1;
      end
      if (usec == 4'd9) seen9 = 1;
      if (k < 0) begin
        if ((mode == 0 && usec == 4'd7) || (mode == 1 && seen9 && usec == 4'd2) ||
            (mode == 2 && usec == 4'd9 && us_tick)) begin
          sync_in = 1'b1; s0 = seconds; k = 0;
        end
      end
    end
    sync_in = 1'b0;
    vectors++;
    if (!done) begin miscompares++; $display("FAIL sync%0d_timeout got=0 exp=1", mode); end
  endtask
`else
  task automatic test_sync_ignored();
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL sync_ign_sb_empty c=%0d", c);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL sync_ignored c=%0d got=%b exp=%b", c, obs, exp_v);
        end
      end
      sync_in = 1'($urandom_range(0, 1));
    end
    sync_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_en_gating();
`ifdef PPS_SYNC_EN
    test_sync(0);
    test_sync(1);
    test_sync(2);
`else
    test_sync_ignored();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
